// File: rtl/factorial_unit.sv
// Iterative factorial accelerator: a two-state controller and a single
// combinational multiplier compute n! with one multiply per cycle. Results
// are reported through a busy/done handshake. Any product that no longer
// fits in DATA_W bits is flagged as an overflow.
module factorial_unit #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [IN_W-1:0]   n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;
    state_t state_next;

    logic [IN_W-1:0]        cnt;
    logic [IN_W-1:0]        cnt_next;
    logic [DATA_W-1:0]      prod;
    logic [DATA_W-1:0]      prod_next;
    logic [DATA_W-1:0]      result_next;
    logic                   busy_next;
    logic                   done_next;
    logic                   err_next;
    logic [DATA_W+IN_W-1:0] full_prod;
    logic                   last_step;
    logic                   overflow;

    // The product is kept at full width so that any carry past DATA_W is visible.
    assign full_prod = {{IN_W{1'b0}}, prod} * {{DATA_W{1'b0}}, cnt};
    assign overflow  = |full_prod[DATA_W+IN_W-1:DATA_W];
    assign last_step = (cnt <= IN_W'(1));

    // Next-state and next-output logic. Everything holds by default, and done is a one-cycle pulse.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        prod_next   = prod;
        result_next = result;
        busy_next   = busy;
        done_next   = 1'b0;
        err_next    = err;
        case (state)
            IDLE: begin
                if (go) begin
                    cnt_next   = n;
                    prod_next  = DATA_W'(1);
                    err_next   = 1'b0;
                    busy_next  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (last_step) begin
                    result_next = prod;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end else if (overflow) begin
                    result_next = '1;
                    err_next    = 1'b1;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end else begin
                    prod_next = full_prod[DATA_W-1:0];
                    cnt_next  = cnt - IN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset. A reset aborts any running operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            prod   <= prod_next;
            result <= result_next;
            busy   <= busy_next;
            done   <= done_next;
            err    <= err_next;
        end
    end

endmodule

// File: tb/tb_factorial_unit.sv
// Directed self-checking bench for factorial_unit. The expected results and
// latencies below are worked out by hand. Outputs are sampled on the falling edge.
module tb_factorial_unit;

    localparam int DATA_W = 32;
    localparam int IN_W   = 5;

    logic              clk;
    logic              rst;
    logic              go;
    logic [IN_W-1:0]   n;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    int checks = 0;
    int errors = 0;

    factorial_unit #(.DATA_W(DATA_W), .IN_W(IN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse go for one accept edge. On return, the bench sits at the falling edge just after the accept edge.
    task automatic start_op(input logic [IN_W-1:0] val);
        @(negedge clk);
        n  = val;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Wait a bounded number of edges for done. The count of edges since the accept edge is returned.
    task automatic wait_done(input int start, input int max_cycles, output int cycles, output bit seen);
        cycles = start;
        seen   = 1'b0;
        while (!seen && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go  = 1'b0;
        n   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, err});
        end
        checks++;
        if (result !== '0) begin
            errors++;
            $display("[TB] FAIL reset_result: got %0d expected 0", result);
        end
        go = 1'b1;
        n  = 5'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_blocks_go: got busy=%b expected 0", busy);
        end
        go  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [1:0] exp_flags;
        start_op(5'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_flags = (k == 5) ? 2'b01 : 2'b10;
            checks++;
            if ({busy, done} !== exp_flags) begin
                errors++;
                $display("[TB] FAIL basic_flags_c%0d: got busy,done=%b expected %b", k, {busy, done}, exp_flags);
            end
        end
        checks++;
        if (result !== 32'd120 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_result: got %0d err=%b expected 120 err=0", result, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 32'd120) begin
            errors++;
            $display("[TB] FAIL basic_pulse_hold: got done=%b result=%0d expected done=0 result=120", done, result);
        end
    endtask

    task automatic test_small();
        int  cyc;
        bit  seen;
        logic [DATA_W-1:0] exp_res [3] = '{32'd1, 32'd1, 32'd2};
        int                exp_cyc [3] = '{1, 1, 2};
        for (int i = 0; i < 3; i++) begin
            start_op(IN_W'(i));
            wait_done(0, 6, cyc, seen);
            checks++;
            if (!seen || cyc != exp_cyc[i]) begin
                errors++;
                $display("[TB] FAIL small_latency_n%0d: got seen=%0d cycles=%0d expected %0d", i, seen, cyc, exp_cyc[i]);
            end
            checks++;
            if (result !== exp_res[i] || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL small_result_n%0d: got %0d err=%b expected %0d err=0", i, result, err, exp_res[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        bit seen;
        start_op(5'd12);
        wait_done(0, 20, cyc, seen);
        checks++;
        if (!seen || cyc != 12 || result !== 32'd479001600 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_n12: got seen=%0d cycles=%0d result=%0d err=%b expected 12 479001600 0", seen, cyc, result, err);
        end
        start_op(5'd13);
        wait_done(0, 20, cyc, seen);
        checks++;
        if (!seen || cyc != 12) begin
            errors++;
            $display("[TB] FAIL ovf_n13_latency: got seen=%0d cycles=%0d expected 12", seen, cyc);
        end
        checks++;
        if (result !== 32'hFFFF_FFFF || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_n13_result: got %h err=%b expected ffffffff err=1", result, err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_err_hold: got err=%b busy=%b expected err=1 busy=0", err, busy);
        end
        start_op(5'd3);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_err_clear: got err=%b expected 0", err);
        end
        wait_done(0, 10, cyc, seen);
        checks++;
        if (!seen || cyc != 3 || result !== 32'd6) begin
            errors++;
            $display("[TB] FAIL ovf_recover: got seen=%0d cycles=%0d result=%0d expected 3 6", seen, cyc, result);
        end
    endtask

    task automatic test_ignore_go();
        int cyc;
        bit seen;
        int extra;
        start_op(5'd6);
        @(negedge clk);
        go = 1'b1;
        n  = 5'd3;
        @(negedge clk);
        go = 1'b0;
        n  = 5'd0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignore_busy: got %b expected 1", busy);
        end
        wait_done(2, 12, cyc, seen);
        checks++;
        if (!seen || cyc != 6 || result !== 32'd720) begin
            errors++;
            $display("[TB] FAIL ignore_result: got seen=%0d cycles=%0d result=%0d expected 6 720", seen, cyc, result);
        end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL ignore_no_requeue: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_abort_reset();
        int cyc;
        bit seen;
        int stray;
        start_op(5'd10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000 || result !== '0) begin
            errors++;
            $display("[TB] FAIL abort_state: got flags=%b result=%0d expected 000 0", {busy, done, err}, result);
        end
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", stray);
        end
        start_op(5'd4);
        wait_done(0, 10, cyc, seen);
        checks++;
        if (!seen || cyc != 4 || result !== 32'd24) begin
            errors++;
            $display("[TB] FAIL abort_recover: got seen=%0d cycles=%0d result=%0d expected 4 24", seen, cyc, result);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        int next_done;
        int done_count;
        @(negedge clk);
        n  = 5'd3;
        go = 1'b1;
        next_done  = 3;
        done_count = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                done_count++;
                checks++;
                if (k != next_done || result !== 32'd6) begin
                    errors++;
                    $display("[TB] FAIL b2b_pulse: got edge=%0d result=%0d expected edge=%0d result=6", k, result, next_done);
                end
                next_done += 4;
            end
        end
        go = 1'b0;
        checks++;
        if (done_count != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 3", done_count);
        end
        wait_done(0, 8, cyc, seen);
        checks++;
        if (!seen || cyc != 3 || result !== 32'd6) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got seen=%0d cycles=%0d result=%0d expected 3 6", seen, cyc, result);
        end
    endtask

    // Run each scenario in order, then report the totals.
    initial begin
        rst = 1'b1;
        go  = 1'b0;
        n   = '0;
        test_reset();
        test_basic();
        test_small();
        test_overflow();
        test_ignore_go();
        test_abort_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
